// File: rtl/crc16_decode.sv
// crc16_decode: serial USB-style packet receiver. Captures PID plus data bits,
// checks the trailing CRC16 against the fixed residual, and reports the
// result as a one-cycle pkt_valid or crc_error pulse.
module crc16_decode #(
    parameter int PKT_LEN = 72,
    parameter int PID_LEN = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               rx_start,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic               eop,
    output logic [PKT_LEN-1:0] pkt_out,
    output logic               pkt_valid,
    output logic               crc_error,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PID   = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic [6:0]  PID_CNT  = 7'(PID_LEN);
    localparam logic [6:0]  PKT_CNT  = 7'(PKT_LEN);
    localparam logic [6:0]  FULL_CNT = 7'(PKT_LEN + 16);
    localparam logic [6:0]  CNT_MAX  = 7'd127;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] RESIDUAL = 16'b1000_0000_0000_1101;

    state_t             state;
    logic [6:0]         bit_cnt;
    logic [15:0]        x;
    logic [PKT_LEN-1:0] capture;

    logic               accept;
    logic               fb;
    logic [6:0]         cnt_next;
    logic [15:0]        x_next;
    logic               good;

    // Next-value view of counter and CRC, so a bit arriving together with
    // eop is already included when the packet is judged.
    always_comb begin
        accept   = in_valid && ((state == PID) || (state == DATA));
        fb       = in_bit ^ x[15];
        cnt_next = bit_cnt;
        x_next   = x;
        if (accept) begin
            cnt_next = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + 7'd1;
            // PID bits are counted and captured but never enter the CRC.
            if (state == DATA) begin
                x_next = {x[14] ^ fb, x[13:2], x[1] ^ fb, x[0], fb};
            end
        end
        good = (cnt_next == FULL_CNT) && (x_next == RESIDUAL);
    end

    // Receive FSM with registered Moore outputs.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            x         <= CRC_INIT;
            capture   <= '0;
            pkt_out   <= '0;
            pkt_valid <= 1'b0;
            crc_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            crc_error <= 1'b0;
            if (rx_start) begin
                // A new SYNC always wins, aborting whatever was in flight.
                state   <= PID;
                bit_cnt <= '0;
                x       <= CRC_INIT;
                capture <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    PID, DATA: begin
                        bit_cnt <= cnt_next;
                        x       <= x_next;
                        if (accept && (bit_cnt < PKT_CNT)) begin
                            capture[bit_cnt] <= in_bit;
                        end
                        if (eop) begin
                            state <= CHECK;
                            busy  <= 1'b0;
                            if (good) begin
                                // A good packet ends on a CRC bit, so capture
                                // is already complete at this edge.
                                pkt_valid <= 1'b1;
                                pkt_out   <= capture;
                            end else begin
                                crc_error <= 1'b1;
                            end
                        end else if ((state == PID) && accept && (cnt_next == PID_CNT)) begin
                            state <= DATA;
                        end
                    end
                    CHECK: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc16_decode.sv
// tb_crc16_decode: table-driven directed bench for crc16_decode, plus
// hand-written sequences for abort and mid-packet reset.
module tb_crc16_decode;

    localparam int PKT_LEN = 72;
    localparam logic [71:0] GOOD1 = 72'h0123_4567_89AB_CDEF_C3;
    localparam logic [71:0] GOOD2 = 72'hFEDC_BA98_7654_3210_A5;

    logic               clock;
    logic               reset_n;
    logic               rx_start;
    logic               in_bit;
    logic               in_valid;
    logic               eop;
    logic [PKT_LEN-1:0] pkt_out;
    logic               pkt_valid;
    logic               crc_error;
    logic               busy;

    crc16_decode #(.PKT_LEN(PKT_LEN), .PID_LEN(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rx_start  (rx_start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .eop       (eop),
        .pkt_out   (pkt_out),
        .pkt_valid (pkt_valid),
        .crc_error (crc_error),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pv_count = 0;
    int ce_count = 0;

    // Count every result pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (pkt_valid) pv_count++;
        if (crc_error) ce_count++;
    end

    typedef struct {
        logic [7:0]  pid;
        logic [63:0] data;
        int          flip;
        int          nbits;
        bit          gaps;
        bit          eop_last;
        bit          exp_pv;
        bit          exp_ce;
        logic [71:0] exp_out;
    } vec_t;

    vec_t vecs[10];
    logic stream[0:127];

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Build PID + data + complemented CRC (MSB first) into stream.
    task automatic build(input logic [7:0] pid, input logic [63:0] data, input int flip);
        logic [15:0] r;
        logic        f;
        r = 16'hFFFF;
        for (int i = 0; i < 8; i++) stream[i] = pid[i];
        for (int i = 0; i < 64; i++) begin
            stream[8 + i] = data[i];
            f = data[i] ^ r[15];
            r = {r[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
        end
        for (int j = 0; j < 16; j++) stream[72 + j] = ~r[15 - j];
        for (int j = 88; j < 128; j++) stream[j] = 1'b0;
        if (flip >= 0) stream[flip] = ~stream[flip];
    endtask

    task automatic send(input int nbits, input bit gaps, input bit eop_last);
        rx_start = 1'b1;
        in_valid = 1'b0;
        eop      = 1'b0;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            in_bit   = stream[i];
            in_valid = 1'b1;
            eop      = eop_last && (i == nbits - 1);
            tick();
            if (gaps && (i != nbits - 1) && (((i + 1) % 6 == 0) || (i == nbits - 2))) begin
                in_valid = 1'b0;
                in_bit   = ~stream[i];
                eop      = 1'b0;
                tick();
            end
        end
        if (!eop_last) begin
            in_valid = 1'b0;
            eop      = 1'b1;
            tick();
        end
        eop      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int p0;
        int c0;
        string nm;

        vecs[0] = '{8'hC3, 64'h0123_4567_89AB_CDEF, -1, 88, 1'b0, 1'b0, 1'b1, 1'b0, GOOD1};
        vecs[1] = '{8'hC3, 64'h0123_4567_89AB_CDEF, 28, 88, 1'b0, 1'b0, 1'b0, 1'b1, GOOD1};
        vecs[2] = '{8'hC3, 64'h0123_4567_89AB_CDEF, -1, 88, 1'b1, 1'b0, 1'b1, 1'b0, GOOD1};
        vecs[3] = '{8'hC3, 64'h0123_4567_89AB_CDEF, -1, 87, 1'b0, 1'b0, 1'b0, 1'b1, GOOD1};
        vecs[4] = '{8'hC3, 64'h0123_4567_89AB_CDEF, -1, 89, 1'b0, 1'b0, 1'b0, 1'b1, GOOD1};
        vecs[5] = '{8'hC3, 64'h0123_4567_89AB_CDEF, -1, 88, 1'b0, 1'b1, 1'b1, 1'b0, GOOD1};
        vecs[6] = '{8'hA5, 64'hFEDC_BA98_7654_3210, -1, 88, 1'b0, 1'b0, 1'b1, 1'b0, GOOD2};
        vecs[7] = '{8'hA5, 64'hFEDC_BA98_7654_3210, 50, 88, 1'b0, 1'b0, 1'b0, 1'b1, GOOD2};
        vecs[8] = '{8'hA5, 64'hFEDC_BA98_7654_3210, -1, 4,  1'b0, 1'b0, 1'b0, 1'b1, GOOD2};
        vecs[9] = '{8'hA5, 64'hFEDC_BA98_7654_3210, -1, 88, 1'b1, 1'b1, 1'b1, 1'b0, GOOD2};

        reset_n  = 1'b1;
        rx_start = 1'b0;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        eop      = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        check("reset_pkt_out", pkt_out, '0);
        check("reset_pkt_valid", pkt_valid, 0);
        check("reset_crc_error", crc_error, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            build(vecs[v].pid, vecs[v].data, vecs[v].flip);
            p0 = pv_count;
            c0 = ce_count;
            send(vecs[v].nbits, vecs[v].gaps, vecs[v].eop_last);
            nm = $sformatf("vec%0d", v);
            check({nm, "_pkt_valid"}, pkt_valid, vecs[v].exp_pv);
            check({nm, "_crc_error"}, crc_error, vecs[v].exp_ce);
            check({nm, "_pkt_out"}, pkt_out, vecs[v].exp_out);
            check({nm, "_busy"}, busy, 0);
            tick();
            check({nm, "_pulse_end"}, {pkt_valid, crc_error}, 2'b00);
            check({nm, "_pv_count"}, pv_count - p0, vecs[v].exp_pv);
            check({nm, "_ce_count"}, ce_count - c0, vecs[v].exp_ce);
        end

        // Abort at bit 40 by a new rx_start, then a complete good packet.
        build(8'hC3, 64'h0123_4567_89AB_CDEF, -1);
        p0 = pv_count;
        c0 = ce_count;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_bit   = stream[i];
            in_valid = 1'b1;
            tick();
        end
        check("abort_busy_mid", busy, 1);
        send(88, 1'b0, 1'b0);
        tick();
        check("abort_pv_count", pv_count - p0, 1);
        check("abort_ce_count", ce_count - c0, 0);
        check("abort_pkt_out", pkt_out, GOOD1);

        // Reset mid-packet at bit 50, then bits and eop without rx_start.
        p0 = pv_count;
        c0 = ce_count;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_bit   = stream[i];
            in_valid = 1'b1;
            tick();
        end
        reset_n = 1'b0;
        #2;
        check("midrst_pkt_out", pkt_out, '0);
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {pkt_valid, crc_error}, 2'b00);
        tick();
        reset_n = 1'b1;
        for (int i = 50; i < 88; i++) begin
            in_bit   = stream[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        eop      = 1'b1;
        tick();
        eop = 1'b0;
        check("postrst_busy", busy, 0);
        tick();
        check("postrst_busy_late", busy, 0);
        check("postrst_pv_count", pv_count - p0, 0);
        check("postrst_ce_count", ce_count - c0, 0);
        check("postrst_pkt_out", pkt_out, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
